// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for a request/valid handshake with programmable latency.
//   Ports:
//     clk, rst      - single rising-edge clock; asynchronous active-high reset
//     request       - access request level, held by the initiator until valid
//     we_re         - 1 = write, 0 = read
//     mask          - byte-lane enables for writes (bit i covers data[8i+7:8i])
//     address       - byte address; word index = address[ADDR_WIDTH+1:2]
//     data_in       - lane-aligned store data
//     valid         - one-cycle response pulse
//     data_out      - registered read word, held across write responses
//     busy          - high while an accepted access is in flight
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic        valid,
    output logic [31:0] data_out,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  we_q, we_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           dout_q, dout_d;
    logic                  live_q;
    logic                  accept;
    logic                  commit;
    logic                  addr_unused;
    logic [31:0]           mem [2**ADDR_WIDTH];

    // Byte offset and bits above the array range are dropped, so addresses alias.
    assign addr_unused = ^{address[31:ADDR_WIDTH+2], address[1:0]};

    // live_q keeps reset out of the combinational paths: no access can start
    // (and so no array write can happen) while rst is held.
    assign accept   = live_q && state_q == IDLE && request;
    assign valid    = state_q == RESP;
    assign busy     = accept || state_q == WAIT;
    assign data_out = dout_q;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        idx_d   = accept ? address[ADDR_WIDTH+1:2] : idx_q;
        we_d    = accept ? we_re : we_q;
        mask_d  = accept ? mask : mask_q;
        wdata_d = accept ? data_in : wdata_q;
        cnt_d   = accept ? CNT_INIT : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        if (accept) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            commit  = LATENCY == 1;
        end else if (state_q == WAIT && cnt_q == 4'd0) begin
            state_d = RESP;
            commit  = 1'b1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        // The _d copies are the live inputs on the accept edge and the latched
        // copies afterwards, so a LATENCY of 1 commits straight from the port.
        dout_d = commit && !we_d ? mem[idx_d] : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            mask_q  <= 4'd0;
            wdata_q <= 32'h0;
            dout_q  <= 32'h0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            live_q  <= 1'b1;
        end
    end

    // Reset clears state_q asynchronously, so a reset before the commit edge
    // removes the commit and the array is left untouched.
    always_ff @(posedge clk) begin
        if (commit && we_d)
            for (int i = 0; i < 4; i++)
                if (mask_d[i]) mem[idx_d][8*i +: 8] <= wdata_d[8*i +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, table-driven bench for mem_responder at LATENCY 2, 1 and 5.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr, wdata;
    logic [2:0]  req, vld, bsy;
    logic [31:0] dout [3];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        w;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .request(req[0]), .we_re(we), .mask(mask), .address(addr),
        .data_in(wdata), .valid(vld[0]), .data_out(dout[0]), .busy(bsy[0]));
    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .request(req[1]), .we_re(we), .mask(mask), .address(addr),
        .data_in(wdata), .valid(vld[1]), .data_out(dout[1]), .busy(bsy[1]));
    mem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) dut2 (
        .clk(clk), .rst(rst), .request(req[2]), .we_re(we), .mask(mask), .address(addr),
        .data_in(wdata), .valid(vld[2]), .data_out(dout[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete access on instance d; request is dropped in the valid cycle.
    task automatic access(input int d, input logic w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int lat, bcnt, exp_lat;
        exp_lat = d == 0 ? 2 : d == 1 ? 1 : 5;
        @(negedge clk);
        we = w; mask = m; addr = a; wdata = wd; req[d] = 1'b1;
        #1;
        bcnt = bsy[d] ? 1 : 0;
        lat = -1;
        rd = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bsy[d]) bcnt++;
            if (vld[d]) begin
                lat = k;
                rd = dout[d];
                break;
            end
        end
        req[d] = 1'b0;
        chk($sformatf("latency_d%0d", d), 32'(lat), 32'(exp_lat));
        chk($sformatf("busy_cycles_d%0d", d), 32'(bcnt), 32'(exp_lat));
        @(negedge clk);
        chk($sformatf("valid_pulse_d%0d", d), 32'(vld[d]), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] bd [3];
        int          bt [3];
        int          n, lat, seen;
        tbl[0]  = '{1'b1, 4'hF,    32'h0000_0040, 32'h1234_5678, 32'h1111_1111};
        tbl[1]  = '{1'b0, 4'h0,    32'h0000_0040, 32'h0,         32'h1234_5678};
        tbl[2]  = '{1'b1, 4'b0100, 32'h0000_0040, 32'hAABB_CCDD, 32'h1234_5678};
        tbl[3]  = '{1'b0, 4'h0,    32'h0000_0040, 32'h0,         32'h12BB_5678};
        tbl[4]  = '{1'b1, 4'h0,    32'h0000_0040, 32'hFFFF_FFFF, 32'h12BB_5678};
        tbl[5]  = '{1'b0, 4'h0,    32'h0000_0040, 32'h0,         32'h12BB_5678};
        tbl[6]  = '{1'b1, 4'hF,    32'h0000_1004, 32'h0000_0055, 32'h12BB_5678};
        tbl[7]  = '{1'b0, 4'h0,    32'h0000_0004, 32'h0,         32'h0000_0055};
        tbl[8]  = '{1'b0, 4'b0010, 32'h0000_0006, 32'h0,         32'h0000_0055};
        tbl[9]  = '{1'b1, 4'hF,    32'h0000_0000, 32'h0000_00A0, 32'h0000_0055};
        tbl[10] = '{1'b1, 4'hF,    32'h0000_0004, 32'h0000_00A4, 32'h0000_0055};
        tbl[11] = '{1'b1, 4'hF,    32'h0000_0008, 32'h0000_00A8, 32'h0000_0055};
        tbl[12] = '{1'b0, 4'h0,    32'h0000_0004, 32'h0,         32'h0000_00A4};
        we = 1'b0; mask = 4'h0; addr = 32'h0; wdata = 32'h0; req = 3'b111;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid_d%0d", d), 32'(vld[d]), 32'h0);
            chk($sformatf("rst_busy_d%0d", d), 32'(bsy[d]), 32'h0);
            chk($sformatf("rst_dout_d%0d", d), dout[d], 32'h0);
        end
        req = 3'b000;
        rst = 1'b0;
        access(0, 1'b1, 4'hF, 32'h10, 32'h1111_1111, rd);
        chk("first_write_dout", rd, 32'h0);
        // Reset in the middle of WAIT aborts the write.
        @(negedge clk);
        we = 1'b1; mask = 4'hF; addr = 32'h10; wdata = 32'hDEAD_BEEF; req[0] = 1'b1;
        @(negedge clk);
        chk("abort_busy_before", 32'(bsy[0]), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_busy_after", 32'(bsy[0]), 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (vld[0]) seen = 1;
        end
        chk("abort_no_valid", 32'(seen), 32'h0);
        access(0, 1'b0, 4'h0, 32'h10, 32'h0, rd);
        chk("abort_old_word", rd, 32'h1111_1111);
        for (int i = 0; i < 13; i++) begin
            access(0, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].wd, rd);
            chk($sformatf("vec%0d_dout", i), rd, tbl[i].exp);
        end
        // Inputs changed after the accept edge must not affect the access.
        @(negedge clk);
        we = 1'b1; mask = 4'hF; addr = 32'h20; wdata = 32'h1357_9BDF; req[0] = 1'b1;
        @(negedge clk);
        we = 1'b0; mask = 4'h0; addr = 32'h24; wdata = 32'h0;
        lat = -1;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (vld[0]) begin
                lat = k;
                break;
            end
        end
        req[0] = 1'b0;
        chk("latched_latency", 32'(lat), 32'h2);
        access(0, 1'b0, 4'h0, 32'h20, 32'h0, rd);
        chk("latched_word", rd, 32'h1357_9BDF);
        // Back-to-back reads with request held high.
        @(negedge clk);
        we = 1'b0; mask = 4'h0; addr = 32'h0; req[0] = 1'b1;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (vld[0]) begin
                if (n < 3) begin
                    bt[n] = c;
                    bd[n] = dout[0];
                end
                n++;
                addr = 32'(4 * n);
                if (n == 3) req[0] = 1'b0;
            end
        end
        req[0] = 1'b0;
        chk("b2b_count", 32'(n), 32'h3);
        for (int j = 0; j < 3 && j < n; j++) begin
            chk($sformatf("b2b_time%0d", j), 32'(bt[j]), 32'(2 + 3 * j));
            chk($sformatf("b2b_data%0d", j), bd[j], 32'(32'hA0 + 4 * j));
        end
        // Latency sweep on the LATENCY=1 and LATENCY=5 instances.
        access(1, 1'b1, 4'hF, 32'h100, 32'hCAFE_F00D, rd);
        chk("lat1_write_dout", rd, 32'h0);
        access(1, 1'b0, 4'h0, 32'h100, 32'h0, rd);
        chk("lat1_read", rd, 32'hCAFE_F00D);
        access(2, 1'b1, 4'hF, 32'h100, 32'h5A5A_A5A5, rd);
        chk("lat5_write_dout", rd, 32'h0);
        access(2, 1'b0, 4'h0, 32'h100, 32'h0, rd);
        chk("lat5_read", rd, 32'h5A5A_A5A5);
        // Reset while valid is high drops it at once.
        @(negedge clk);
        we = 1'b0; mask = 4'h0; addr = 32'h40; req[0] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (vld[0]) begin
                seen = 1;
                break;
            end
        end
        chk("resp_valid_seen", 32'(seen), 32'h1);
        chk("resp_dout", dout[0], 32'h12BB_5678);
        rst = 1'b1;
        #1;
        chk("resp_rst_valid", 32'(vld[0]), 32'h0);
        chk("resp_rst_dout", dout[0], 32'h0);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
